// File: rtl/ml_pkg.sv
// Shared definitions for the ML accelerator blocks: controller opcodes,
// handshake bit positions and the input-feature FIFO state encoding.
package ml_pkg;

    // Opcodes carried on the 2-bit controller-to-block command bus.
    typedef enum logic [1:0] {
        FSM_IN_NONE  = 2'b00,
        FSM_IN_LOAD  = 2'b01,
        FSM_IN_DRAIN = 2'b10,
        FSM_IN_BOTH  = 2'b11
    } fsm_input_e;

    // Bit positions inside if_fifo_ctrl / if_fifo_resp.
    localparam int CTRL_LOAD_BIT       = 0;
    localparam int CTRL_DRAIN_BIT      = 1;
    localparam int RESP_LOAD_DONE_BIT  = 0;
    localparam int RESP_DRAIN_DONE_BIT = 1;

    // Response codes driven back to the controller.
    localparam logic [1:0] RESP_NONE       = 2'b00;
    localparam logic [1:0] RESP_LOAD_DONE  = 2'b01;
    localparam logic [1:0] RESP_DRAIN_DONE = 2'b10;

    // Input-feature FIFO controller states.
    typedef enum logic [2:0] {
        IFF_IDLE      = 3'd0,
        IFF_LOAD      = 3'd1,
        IFF_LOAD_WAIT = 3'd2,
        IFF_READY     = 3'd3,
        IFF_DRAIN     = 3'd4,
        IFF_DRAINED   = 3'd5
    } if_fifo_state_e;

endpackage

// File: rtl/ml_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Pointers wrap naturally at
// DEPTH (power of two); storage is intentionally left unreset.
module ml_sync_fifo
    import ml_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ml_if_fifo.sv
// Input-feature buffer: loads a burst of words from SRAM into a local FIFO,
// then streams them to the PE array with a valid/ready handshake while
// stepping the target PE row.
//
// Handshake: a word moves to the PE array on every rising edge where
// pe_if_valid and pe_if_ready are both high; valid never depends on ready,
// and while ready is low the data, row and count are held.
module ml_if_fifo
    import ml_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 10,
    parameter int Y_DIM  = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   if_fifo_ctrl,
    output logic [1:0]                   if_fifo_resp,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [$clog2(DEPTH):0]       load_len,
    output logic                         sram_rd_en,
    output logic [ADDR_W-1:0]            sram_rd_addr,
    input  logic [DATA_W-1:0]            sram_rd_data,
    output logic [DATA_W-1:0]            pe_if_data,
    output logic                         pe_if_valid,
    input  logic                         pe_if_ready,
    output logic [$clog2(Y_DIM)-1:0]     pe_if_row,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output if_fifo_state_e               dbg_state
);

    localparam int LEN_W = $clog2(DEPTH) + 1;
    localparam int ROW_W = $clog2(Y_DIM);

    if_fifo_state_e     r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issue;
    logic               r_rd_en;
    logic               r_rd_pend;
    logic [1:0]         r_resp;
    logic [ROW_W-1:0]   r_row;

    logic [LEN_W-1:0]   w_len_eff;
    logic               w_last_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [LEN_W-1:0]   w_count;

    // Zero or oversized lengths mean "fill the whole buffer".
    assign w_len_eff    = ((load_len == '0) || (load_len > LEN_W'(DEPTH)))
                          ? LEN_W'(DEPTH) : load_len;
    assign w_last_issue = (r_issue == (r_len - LEN_W'(1)));

    // Read data lands one cycle after its strobe; r_rd_pend marks that cycle.
    assign w_push       = r_rd_pend && !w_full;
    assign pe_if_valid  = (r_state == IFF_DRAIN) && !w_empty;
    assign w_pop        = pe_if_valid && pe_if_ready;

    assign sram_rd_en   = r_rd_en;
    assign sram_rd_addr = r_base + ADDR_W'(r_issue);
    assign if_fifo_resp = r_resp;
    assign pe_if_row    = r_row;
    assign fifo_count   = w_count;
    assign dbg_state    = r_state;

    ml_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (sram_rd_data),
        .i_pop   (w_pop),
        .o_rdata (pe_if_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Load/drain sequencer with registered strobe, response and row outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IFF_IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_issue   <= '0;
            r_rd_en   <= 1'b0;
            r_rd_pend <= 1'b0;
            r_resp    <= RESP_NONE;
            r_row     <= '0;
        end else begin
            r_rd_pend <= r_rd_en;
            case (r_state)
                IFF_IDLE: begin
                    if (if_fifo_ctrl[CTRL_LOAD_BIT]) begin
                        r_state <= IFF_LOAD;
                        r_base  <= base_addr;
                        r_len   <= w_len_eff;
                        r_issue <= '0;
                        r_rd_en <= 1'b1;
                    end
                end
                IFF_LOAD: begin
                    r_issue <= r_issue + LEN_W'(1);
                    if (w_last_issue) begin
                        r_state <= IFF_LOAD_WAIT;
                        r_rd_en <= 1'b0;
                    end
                end
                IFF_LOAD_WAIT: begin
                    r_state <= IFF_READY;
                    r_resp  <= RESP_LOAD_DONE;
                end
                IFF_READY: begin
                    if (if_fifo_ctrl[CTRL_DRAIN_BIT]) begin
                        r_state <= IFF_DRAIN;
                        r_resp  <= RESP_NONE;
                        r_row   <= '0;
                    end
                end
                IFF_DRAIN: begin
                    if (w_pop) begin
                        r_row <= (r_row == ROW_W'(Y_DIM - 1)) ? '0 : r_row + ROW_W'(1);
                        if (w_count == LEN_W'(1)) begin
                            r_state <= IFF_DRAINED;
                            r_resp  <= RESP_DRAIN_DONE;
                        end
                    end else if (w_empty) begin
                        r_state <= IFF_DRAINED;
                        r_resp  <= RESP_DRAIN_DONE;
                    end
                end
                IFF_DRAINED: begin
                    if (if_fifo_ctrl == FSM_IN_NONE) begin
                        r_state <= IFF_IDLE;
                        r_resp  <= RESP_NONE;
                    end
                end
                default: begin
                    r_state <= IFF_IDLE;
                    r_rd_en <= 1'b0;
                    r_resp  <= RESP_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ml_if_fifo.sv
// Self-checking bench for ml_if_fifo: table of load/drain scenarios plus
// hand-written reset and command-ignore sequences.
module tb_ml_if_fifo;
    import ml_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 10;
    localparam int Y_DIM  = 15;

    logic                 clk;
    logic                 rst;
    logic [1:0]           if_fifo_ctrl;
    logic [1:0]           if_fifo_resp;
    logic [ADDR_W-1:0]    base_addr;
    logic [4:0]           load_len;
    logic                 sram_rd_en;
    logic [ADDR_W-1:0]    sram_rd_addr;
    logic [DATA_W-1:0]    sram_rd_data;
    logic [DATA_W-1:0]    pe_if_data;
    logic                 pe_if_valid;
    logic                 pe_if_ready;
    logic [3:0]           pe_if_row;
    logic [4:0]           fifo_count;
    if_fifo_state_e       dbg_state;

    int total = 0;
    int bad   = 0;
    logic [15:0] salt = 16'h1234;
    logic [DATA_W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]        start_ctrl;
        logic [ADDR_W-1:0] base;
        logic [4:0]        len;
        int                mode;
        int                exp_cnt;
    } vec_t;

    vec_t vecs[6];

    ml_if_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .Y_DIM  (Y_DIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_fifo_ctrl (if_fifo_ctrl),
        .if_fifo_resp (if_fifo_resp),
        .base_addr    (base_addr),
        .load_len     (load_len),
        .sram_rd_en   (sram_rd_en),
        .sram_rd_addr (sram_rd_addr),
        .sram_rd_data (sram_rd_data),
        .pe_if_data   (pe_if_data),
        .pe_if_valid  (pe_if_valid),
        .pe_if_ready  (pe_if_ready),
        .pe_if_row    (pe_if_row),
        .fifo_count   (fifo_count),
        .dbg_state    (dbg_state)
    );

    // Clock and global watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a, input logic [15:0] s);
        logic [15:0] w;
        w = {6'd0, a} * 16'd7;
        return w ^ s;
    endfunction

    // SRAM model: one-cycle read latency
    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= sram_word(sram_rd_addr, salt);
        else            sram_rd_data <= 16'hDEAD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_load(input logic [1:0] sc, input logic [ADDR_W-1:0] base,
                           input logic [4:0] len, input int exp_cnt);
        logic [ADDR_W-1:0] exp_a;
        @(negedge clk);
        if_fifo_ctrl = sc;
        base_addr    = base;
        load_len     = len;
        @(negedge clk);
        // Inputs are only sampled at load start; scramble them now.
        if_fifo_ctrl = 2'b00;
        base_addr    = 10'h155;
        load_len     = 5'd1;
        for (int i = 0; i < exp_cnt; i++) begin
            exp_a = base + ADDR_W'(i);
            chk("load_rd_en", 32'(sram_rd_en), 32'd1);
            chk("load_rd_addr", 32'(sram_rd_addr), 32'(exp_a));
            chk("load_resp", 32'(if_fifo_resp), 32'd0);
            exp_q.push_back(sram_word(exp_a, salt));
            @(negedge clk);
        end
        chk("wait_rd_en", 32'(sram_rd_en), 32'd0);
        chk("wait_resp", 32'(if_fifo_resp), 32'd0);
        chk("wait_state", 32'(dbg_state), 32'(IFF_LOAD_WAIT));
        @(negedge clk);
        chk("ready_resp", 32'(if_fifo_resp), 32'd1);
        chk("ready_count", 32'(fifo_count), 32'(exp_cnt));
        chk("ready_state", 32'(dbg_state), 32'(IFF_READY));
    endtask

    task automatic do_drain(input int mode, input int exp_cnt);
        int n;
        int cyc;
        int exp_row;
        logic rdy;
        @(negedge clk);
        if_fifo_ctrl = 2'b01;
        pe_if_ready  = 1'b0;
        @(negedge clk);
        chk("ready_ignores_load", 32'(dbg_state), 32'(IFF_READY));
        if_fifo_ctrl = 2'b10;
        @(negedge clk);
        if_fifo_ctrl = 2'b00;
        n = 0;
        cyc = 0;
        exp_row = 0;
        while (n < exp_cnt && cyc < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pe_if_ready = rdy;
            chk("drain_valid", 32'(pe_if_valid), 32'd1);
            chk("drain_row", 32'(pe_if_row), 32'(exp_row));
            chk("drain_count", 32'(fifo_count), 32'(exp_cnt - n));
            chk("drain_resp", 32'(if_fifo_resp), 32'd0);
            if (exp_q.size() == 0) begin
                chk("drain_sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("drain_data", 32'(pe_if_data), 32'(exp_q[0]));
            end
            if (rdy) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n++;
                exp_row = (exp_row == Y_DIM - 1) ? 0 : exp_row + 1;
            end
            cyc++;
            @(negedge clk);
        end
        chk("drain_words", 32'(n), 32'(exp_cnt));
        if (mode == 0) chk("drain_cycles", 32'(cyc), 32'(exp_cnt));
        chk("drained_valid", 32'(pe_if_valid), 32'd0);
        chk("drained_resp", 32'(if_fifo_resp), 32'd2);
        chk("drained_state", 32'(dbg_state), 32'(IFF_DRAINED));
        chk("drained_count", 32'(fifo_count), 32'd0);
        pe_if_ready = 1'b0;
        @(negedge clk);
        chk("idle_resp", 32'(if_fifo_resp), 32'd0);
        chk("idle_state", 32'(dbg_state), 32'(IFF_IDLE));
    endtask

    initial begin
        vecs[0] = '{2'b01, 10'h040, 5'd4,  0, 4};
        vecs[1] = '{2'b01, 10'h3FE, 5'd4,  1, 4};
        vecs[2] = '{2'b01, 10'h100, 5'd16, 0, 16};
        vecs[3] = '{2'b11, 10'h200, 5'd0,  1, 16};
        vecs[4] = '{2'b01, 10'h010, 5'd3,  2, 3};
        vecs[5] = '{2'b01, 10'h3F8, 5'd20, 2, 16};

        rst          = 1'b0;
        if_fifo_ctrl = 2'b00;
        base_addr    = '0;
        load_len     = '0;
        pe_if_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(IFF_IDLE));
        chk("rst_rd_en", 32'(sram_rd_en), 32'd0);
        chk("rst_valid", 32'(pe_if_valid), 32'd0);
        chk("rst_resp", 32'(if_fifo_resp), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_row", 32'(pe_if_row), 32'd0);
        rst = 1'b1;

        // Drain request alone must be ignored in IDLE.
        @(negedge clk);
        if_fifo_ctrl = 2'b10;
        @(negedge clk);
        chk("idle_ignores_drain", 32'(dbg_state), 32'(IFF_IDLE));
        chk("idle_ignores_drain_rd", 32'(sram_rd_en), 32'd0);
        if_fifo_ctrl = 2'b00;

        for (int v = 0; v < 6; v++) begin
            salt = salt + 16'h1111;
            exp_q.delete();
            do_load(vecs[v].start_ctrl, vecs[v].base, vecs[v].len, vecs[v].exp_cnt);
            do_drain(vecs[v].mode, vecs[v].exp_cnt);
        end

        // Reset in the middle of a load: in-flight data must be dropped.
        exp_q.delete();
        salt = 16'hBEEF;
        @(negedge clk);
        if_fifo_ctrl = 2'b01;
        base_addr    = 10'h080;
        load_len     = 5'd8;
        @(negedge clk);
        if_fifo_ctrl = 2'b00;
        chk("mid_rd_addr0", 32'(sram_rd_addr), 32'h080);
        @(negedge clk);
        chk("mid_rd_addr1", 32'(sram_rd_addr), 32'h081);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_rd_en", 32'(sram_rd_en), 32'd0);
        chk("mid_rst_resp", 32'(if_fifo_resp), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'(IFF_IDLE));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_discard", 32'(fifo_count), 32'd0);
        salt = 16'h0F0F;
        do_load(2'b01, 10'h0C0, 5'd5, 5);
        do_drain(0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ml_if_fifo.md
ML_IF_FIFO -- requirements
Module: ml_if_fifo

Interface
REQ-001 Parameter DATA_W, default 16, width of one input-feature word.
REQ-002 Parameter DEPTH, default 16, FIFO word capacity; SHALL be a power of two, >=2.
REQ-003 Parameter ADDR_W, default 10, SRAM word-address width.
REQ-004 Parameter Y_DIM, default 15, PE rows addressed by pe_if_row.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 if_fifo_ctrl  in  2  bit0 = load request (SRAM->buffer); bit1 = drain request (buffer->PE).
REQ-008 if_fifo_resp  out  2  bit0 = load complete (level); bit1 = drain complete (level).
REQ-009 base_addr  in  ADDR_W  first SRAM address of the load; sampled at load start.
REQ-010 load_len  in  $clog2(DEPTH)+1  words to load; sampled at load start.
REQ-011 sram_rd_en  out  1  SRAM read strobe.
REQ-012 sram_rd_addr  out  ADDR_W  SRAM read address.
REQ-013 sram_rd_data  in  DATA_W  read data, valid exactly one cycle after sram_rd_en.
REQ-014 pe_if_data  out  DATA_W  word presented to the PE array.
REQ-015 pe_if_valid  out  1  pe_if_data valid.
REQ-016 pe_if_ready  in  1  PE accepts word; transfer when valid&ready.
REQ-017 pe_if_row  out  $clog2(Y_DIM)  target PE row of the current word.
REQ-018 fifo_count  out  $clog2(DEPTH)+1  words currently stored.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, LOAD_WAIT, READY, DRAIN, DRAINED.
REQ-020 IDLE: if_fifo_ctrl[0]=1 -> LOAD, latch base_addr and load_len (load_len=0 or >DEPTH treated as DEPTH), clear issue counter; bit1 ignored if bit0 also set.
REQ-021 LOAD: sram_rd_en=1 every cycle, sram_rd_addr=latched base + issue count, until load_len reads issued; after the last issue -> LOAD_WAIT.
REQ-022 Each returned sram_rd_data SHALL be written to the FIFO the cycle after its strobe; ADDR_W addition wraps modulo 2^ADDR_W.
REQ-023 LOAD_WAIT: one cycle, captures final word, -> READY.
REQ-024 READY: if_fifo_resp=01; if_fifo_ctrl[1]=1 -> DRAIN, pe_if_row cleared to 0.
REQ-025 DRAIN: pe_if_valid=1 while fifo_count>0, pe_if_data = head word (first-word-fall-through, no extra latency); drain continues regardless of later if_fifo_ctrl[1] value.
REQ-026 Each valid&ready transfer SHALL pop one word and advance pe_if_row, wrapping Y_DIM-1 -> 0; pe_if_ready=0 holds data, row and count.
REQ-027 Transfer of the last stored word -> DRAINED next cycle; pe_if_valid=0 there.
REQ-028 DRAINED: if_fifo_resp=10; if_fifo_ctrl==00 -> IDLE.
REQ-029 if_fifo_resp SHALL be 00 in IDLE, LOAD, LOAD_WAIT, DRAIN.
REQ-030 if_fifo_ctrl[0] in LOAD/READY/DRAIN/DRAINED and bit1 in LOAD/LOAD_WAIT SHALL be ignored; no overflow possible since load_len<=DEPTH.
REQ-031 Read/write pointers SHALL be $clog2(DEPTH) bits, wrapping at DEPTH; fifo_count increments on push, decrements on pop.

Reset
REQ-032 rst=0 at a clock edge: state=IDLE, pointers, fifo_count, issue counter, pe_if_row=0; sram_rd_en=0, pe_if_valid=0, if_fifo_resp=00; storage contents not reset.
REQ-033 Reset mid-LOAD: read data returning the cycle after reset SHALL be discarded.

Structure
REQ-034 Shared package ml_pkg SHALL hold fsm_input opcodes, if_fifo_ctrl/resp bit indices, and this block's state enum.
REQ-035 Storage, pointers and count SHALL be sub-module ml_sync_fifo (push, pop, full, empty, count); FSM and SRAM addressing stay in ml_if_fifo.

Verification
REQ-036 base_addr=0x040, load_len=4, ctrl=01 -> sram_rd_addr 0x040..0x043 on 4 consecutive cycles, resp=01 two cycles after last strobe, fifo_count=4.
REQ-037 Then ctrl=10, pe_if_ready=1 -> words D0..D3 on 4 consecutive cycles, pe_if_row 0,1,2,3, resp=10 next cycle; ctrl=00 -> IDLE, resp=00.
REQ-038 load_len=16 (DEPTH), drain with Y_DIM=15 -> pe_if_row 0..14 then 0 on word 16.
REQ-039 pe_if_ready toggled 1,0,0,1 during drain -> data/row held on 0 cycles, no word lost or duplicated.
REQ-040 base_addr=0x3FE, load_len=4 -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-041 rst=0 during LOAD after 2 strobes -> next cycle fifo_count=0, sram_rd_en=0, resp=00; fresh load afterwards returns only new data.
